serial_adder_fsm: RTL and testbench
===================================

Name: serial_adder_fsm

Overview:
Bit-serial adder built around the existing full_adder_hf cell.
- The cell is instantiated once, in the order (sum, carry, a, b, cin).
- Its carry output is fed back through a flip-flop to its cin input.
- Two WIDTH-bit operands are captured on a start pulse and shifted LSB-first through the cell, one bit per clock.
- The full sum and carry-out are presented with a one-cycle done strobe.
- Intended as a low-area arithmetic stage downstream of operand registers.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request: capture a, b, cin and begin an add (sampled in IDLE only)
a      input   WIDTH  operand A, sampled on accepted start
b      input   WIDTH  operand B, sampled on accepted start
cin    input   1      carry-in, sampled on accepted start
busy   output  1      high while in SHIFT or DONE
done   output  1      one-cycle strobe: sum/cout valid
sum    output  WIDTH  result, held until next accepted start
cout   output  1      final carry-out, held with sum

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, carry FF and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a clock edge: load a into shift reg SA, b into SB, cin into carry FF; clear sum; count=0; go to SHIFT.
  - If start=0: remain in IDLE; sum/cout hold their last values.
- SHIFT, on each edge:
  - The cell sees a=SA[0], b=SB[0], cin=carry FF.
  - Cell sum shifts into sum from the MSB side: sum <= {cell_sum, sum[WIDTH-1:1]}.
  - carry FF <= cell carry; SA, SB shift right by one; count increments.
  - On the edge where count reaches WIDTH-1: cout <= cell carry, state <= DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: the start edge is edge 0; done is high in the cycle after edge WIDTH+... specifically, done is registered high after edge WIDTH, i.e. the add takes WIDTH+1 clocks from accepted start to done.
- Throughput: one add per WIDTH+2 clocks (an IDLE cycle is required between adds).
- busy: combinational decode, high in SHIFT and DONE.
- done: registered, high only in DONE.
- start while busy (SHIFT or DONE) is ignored; it is neither queued nor able to corrupt the in-flight operands.
- a, b, cin may change freely after the accepted start edge without effect.
- Arithmetic: result equals (a + b + cin) mod 2^WIDTH; cout is bit WIDTH of the true sum.
- WIDTH=1: SHIFT lasts one cycle; done is high 2 clocks after start.
- Counter width is clog2(WIDTH)+1. The counter never wraps because it resets on each start.
- Reset asserted mid-SHIFT aborts the add: no done is issued and all outputs return to 0.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), treating operands as two's-complement.
  - ovf <= cell carry XOR carry FF on the final SHIFT edge (carry into MSB xor carry out of MSB).
  - ovf is valid with done, held until the next accepted start, and reset to 0.
- Not defined:
  - ovf port and its logic are absent.
  - Port list and behaviour are otherwise identical.

Test Plan:
1. WIDTH=8; a=0x00, b=0x00, cin=0, one start pulse -> busy high next cycle; done high exactly 9 clocks after start edge; sum=0x00, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
3. Start a=0x10, b=0x20; on cycle 3 of SHIFT pulse start with a=0xFF, b=0xFF -> second start ignored; result sum=0x30, cout=0; only one done pulse.
4. Start a=0xFF, b=0xFF, cin=1; deassert rst_n mid-SHIFT (asynchronously, between edges) -> busy, done, sum, cout drop to 0 immediately; no done follows. After release, a fresh add of 0x01+0x01 gives sum=0x02.
5. With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1, cout=0. 0x80+0x80 -> sum=0x00, ovf=1, cout=1. 0x40+0x20 -> ovf=0.
6. Exhaustive loop, WIDTH=4: all 512 combinations of a, b, cin against the reference (a+b+cin), back-to-back starts issued as soon as busy falls -> no mismatches; every add has done spacing of 6 clocks.

Source files
------------

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full_adder_hf cell, carry recirculated through a flip-flop.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder_hf (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit pair added per clock, LSB first
// DONE  | one-cycle done strobe, returns to IDLE unconditionally
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             cout_q;
    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;

    full_adder_hf u_fa (
        .sum   (cell_sum),
        .carry (cell_carry),
        .a     (sa[0]),
        .b     (sb[0]),
        .cin   (carry_q)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift = cell_sum;
        end else begin : g_sum_wn
            assign sum_shift = {cell_sum, sum_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        carry_q <= cin;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    sum_q   <= sum_shift;
                    carry_q <= cell_carry;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_q <= cell_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the MSB is carry_q on the final edge; carry out is cell_carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_q <= cell_carry ^ carry_q;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm: an 8-bit instance for directed vectors and a
// 4-bit instance for the exhaustive sweep; ovf is checked when SERIAL_ADDER_OVF_EN is set.

module tb_serial_adder_fsm;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         n_assert;
    int         n_fail;
    exp_t       q8[$];
    exp_t       q4[$];
    int         last4;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    serial_adder_fsm #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder_fsm #(.WIDTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Signed-range reference for two's-complement overflow.
    function automatic logic ovf_ref(input int w, input logic [7:0] aa, input logic [7:0] bb,
                                     input logic cc);
        int sa, sb, s;
        sa = (aa[w-1]) ? int'(aa) - (1 << w) : int'(aa);
        sb = (bb[w-1]) ? int'(bb) - (1 << w) : int'(bb);
        s  = sa + sb + int'(cc);
        return (s > (1 << (w-1)) - 1) || (s < -(1 << (w-1)));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL done8_unexpected: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                e = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e.sum));
                chk("cout8", 32'(cout8), 32'(e.cout));
                chk("done8_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL done4_unexpected: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                e = q4.pop_front();
                chk("sum4", 32'(sum4), 32'(e.sum));
                chk("cout4", 32'(cout4), 32'(e.cout));
                chk("done4_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
                if (last4 >= 0) chk("done4_spacing", 32'(cyc - last4), 32'd6);
                last4 = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge where the instance is idle again.
    task automatic wait_idle8();
        int n = 0;
        while (busy8 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle8_timeout: got busy=%b expected 0", busy8);
        end
    endtask

    task automatic run8(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                        input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        wait_idle8();
        a8 = aa; b8 = bb; cin8 = cc; start8 = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~aa; b8 = ~bb; cin8 = ~cc;
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] aa, input logic [3:0] bb, input logic cc);
        exp_t e;
        int n = 0;
        logic [4:0] full;
        while (busy4 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle4_timeout: got busy=%b expected 0", busy4);
        end
        full = 5'(aa) + 5'(bb) + 5'(cc);
        a4 = aa; b4 = bb; cin4 = cc; start4 = 1'b1;
        e.sum = {4'h0, full[3:0]}; e.cout = full[4];
        e.ovf = ovf_ref(4, {4'h0, aa}, {4'h0, bb}, cc);
        e.cyc = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~aa; b4 = ~bb; cin4 = ~cc;
    endtask

    initial begin
        exp_t e;
        n_assert = 0; n_fail = 0; last4 = -1;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_sum", 32'(sum8), 32'd0);
        chk("reset_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero add, busy one cycle after start
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        e.sum = 8'h00; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_start", 32'(busy8), 32'd1);

        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);

        // start during SHIFT is ignored
        wait_idle8();
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        e.sum = 8'h30; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        wait_idle8();
        repeat (3) @(negedge clk);
        chk("q8_drained_after_ignored_start", 32'(q8.size()), 32'd0);

        // asynchronous reset mid-SHIFT aborts the add
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'd0);
        chk("abort_cout", 32'(cout8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", 32'(busy8), 32'd0);
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8(8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0);
`endif
        wait_idle8();

        // exhaustive WIDTH=4 sweep, back-to-back
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run4(v[3:0], v[7:4], v[8]);
        end
        repeat (10) @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
